renkon_ctrl_layer: RTL
======================

RENKON_CTRL_LAYER -- requirements
Module: renkon_ctrl_layer

Interface
REQ-001 Parameters SHALL be: CORE (8), number of parallel cores; LWIDTH (12), layer-count width; MEMSIZE (12), image address width; NETSIZE (11), weight address width; QDEPTH (4), descriptor queue depth (power of two).
REQ-002 Ports SHALL be, clock and reset first:
- clk, in, 1: clock.
- xrst, in, 1: reset, asynchronous, active-low.
- clear, in, 1: synchronous flush.
- desc_valid, in, 1: descriptor offered.
- desc_ready, out, 1: queue not full.
- desc_total_in / desc_total_out, in, LWIDTH each: input / output channels.
- desc_in_size / desc_out_size, in, MEMSIZE each: words per input / output channel.
- desc_in_offset / desc_out_offset, in, MEMSIZE each: image base addresses.
- desc_net_offset / desc_net_stride, in, NETSIZE each: weight base address; weight words per (group, input).
- run_start, out, 1: one-cycle pass start pulse.
- run_in_addr / run_out_addr, out, MEMSIZE each: pass addresses.
- run_net_addr, out, NETSIZE: pass weight address.
- first_input / last_input, out, 1 each: pass position within the input loop.
- core_mask, out, CORE: cores enabled for this pass.
- run_done, in, 1: datapath finished the pass.
- layer_done, out, 1: one-cycle pulse per retired descriptor.
- busy, out, 1: high when not in IDLE or queue non-empty.
- ack, out, 1: high when the queue is empty and the FSM is in IDLE.

Function
REQ-003 The descriptor FIFO SHALL accept a descriptor on desc_valid && desc_ready; desc_ready = count < QDEPTH; a simultaneous push and pop SHALL keep count unchanged.
REQ-004 FSM states SHALL be IDLE, FETCH, START, WAIT, NEXT.
- IDLE -> FETCH when the queue is non-empty.
- FETCH pops one descriptor into working registers, then goes to START; it goes to NEXT (skip) if total_in==0 or total_out==0.
- START asserts run_start for exactly one cycle, then goes to WAIT.
- WAIT -> NEXT on run_done.
- NEXT advances the indices and goes to START, or on layer end pulses layer_done and goes to IDLE.
REQ-005 Loop nest: group g in 0..G-1 with G = ceil(total_out/CORE) outer; input i in 0..total_in-1 inner; i resets to 0 when g increments.
REQ-006 Pass outputs SHALL be registered, stable from the run_start cycle through the run_done cycle, and computed with incremental adders only (no multipliers):
- run_in_addr = in_offset + i*in_size.
- run_out_addr = out_offset + g*CORE*out_size.
- run_net_addr = net_offset + (g*total_in + i)*net_stride.
REQ-007 first_input = (i==0) and last_input = (i==total_in-1); both SHALL be high when total_in==1.
REQ-008 core_mask SHALL be all ones except on the last group, where bit k = (k < total_out - g*CORE).
REQ-009 run_done SHALL be ignored outside WAIT.
REQ-010 Address sums SHALL wrap modulo 2^MEMSIZE and 2^NETSIZE.
REQ-011 A skipped (zero-size) layer SHALL pulse layer_done with no run_start.
REQ-012 clear SHALL empty the FIFO, force IDLE and deassert run_start within one cycle; a run_done arriving later SHALL be ignored.
REQ-013 A desc_valid in the same cycle as clear SHALL be dropped.
REQ-014 Latency from push into an idle empty queue to run_start SHALL be 3 cycles.

Reset
REQ-015 While xrst is low, all of the following SHALL be 0: FIFO pointers and count, state (IDLE), indices, run_start, layer_done, first_input, last_input, core_mask, and all address outputs. busy SHALL be 0 and ack SHALL be 1.
REQ-016 Reset mid-layer SHALL discard the layer silently, with no layer_done pulse.

Configuration
REQ-017 With RENKON_LAYER_PERF_EN defined, the block SHALL have an output perf_cycles[31:0] that:
- counts cycles from FETCH to layer_done inclusive, saturating at 2^32-1;
- latches the count on layer_done;
- resets to 0.
REQ-018 Without RENKON_LAYER_PERF_EN, perf_cycles and its counter SHALL be absent.

Structure
REQ-019 The package renkon_pkg SHALL hold:
- the descriptor struct typedef (layer_desc_t);
- the FSM state enum;
- CORE, LWIDTH, MEMSIZE and NETSIZE default constants.
REQ-020 The descriptor queue SHALL be the sub-module renkon_desc_fifo, parametrised by QDEPTH and the descriptor type.

Verification
REQ-021 Directed scenarios:
- CORE=8, one descriptor (total_in=3, total_out=20, in_size=16, out_size=16, offsets 0, stride 9) -> 9 run_start pulses with G=3. core_mask: 0xFF, 0xFF, 0x0F. run_net_addr: 0,9,…,72.
- total_in=1 -> first_input and last_input both high on every pass.
- total_out=0 -> layer_done pulses with no run_start; ack returns high.
- Push 5 descriptors back-to-back, QDEPTH=4, no pops -> desc_ready low after the 4th push; 5th held until FETCH pops.
- clear in WAIT, then a run_done 2 cycles later -> IDLE, queue empty, no layer_done, no further run_start.
- xrst low mid-pass -> all outputs at reset values next cycle; after release, a new descriptor runs from i=0, g=0.

Source files
------------

// File: rtl/renkon_pkg.sv
// Shared types and default sizes for the renkon layer controller.
package renkon_pkg;

    localparam int DEF_CORE    = 8;
    localparam int DEF_LWIDTH  = 12;
    localparam int DEF_MEMSIZE = 12;
    localparam int DEF_NETSIZE = 11;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        WAIT,
        NEXT
    } state_t;

    typedef struct packed {
        logic [DEF_LWIDTH-1:0]  total_in;
        logic [DEF_LWIDTH-1:0]  total_out;
        logic [DEF_MEMSIZE-1:0] in_size;
        logic [DEF_MEMSIZE-1:0] out_size;
        logic [DEF_MEMSIZE-1:0] in_offset;
        logic [DEF_MEMSIZE-1:0] out_offset;
        logic [DEF_NETSIZE-1:0] net_offset;
        logic [DEF_NETSIZE-1:0] net_stride;
    } layer_desc_t;

endpackage

// File: rtl/renkon_desc_fifo.sv
// Layer descriptor queue; QDEPTH must be a power of two, at least 2.
module renkon_desc_fifo
    import renkon_pkg::*;
#(
    parameter int  QDEPTH = 4,
    parameter type desc_t = layer_desc_t
) (
    input  logic  clk,
    input  logic  xrst,
    input  logic  clear,
    input  logic  push,
    input  desc_t push_desc,
    output logic  ready,
    input  logic  pop,
    output desc_t pop_desc,
    output logic  empty
);

    localparam int AW = $clog2(QDEPTH);

    desc_t         mem [QDEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    // A push coinciding with clear is dropped along with the queue contents.
    assign ready    = count < (AW+1)'(QDEPTH);
    assign empty    = count == '0;
    assign push_ok  = push && ready && !clear;
    assign pop_ok   = pop && !empty && !clear;
    assign pop_desc = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_desc;
        end
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + (AW+1)'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/renkon_ctrl_layer.sv
// Layer sequencer: walks (group, input) passes for each queued descriptor.
// Define RENKON_LAYER_PERF_EN to add the perf_cycles layer cycle counter.
module renkon_ctrl_layer
    import renkon_pkg::*;
#(
    parameter int CORE    = DEF_CORE,
    parameter int LWIDTH  = DEF_LWIDTH,
    parameter int MEMSIZE = DEF_MEMSIZE,
    parameter int NETSIZE = DEF_NETSIZE,
    parameter int QDEPTH  = 4
) (
    input  logic               clk,
    input  logic               xrst,
    input  logic               clear,
    input  logic               desc_valid,
    output logic               desc_ready,
    input  logic [LWIDTH-1:0]  desc_total_in,
    input  logic [LWIDTH-1:0]  desc_total_out,
    input  logic [MEMSIZE-1:0] desc_in_size,
    input  logic [MEMSIZE-1:0] desc_out_size,
    input  logic [MEMSIZE-1:0] desc_in_offset,
    input  logic [MEMSIZE-1:0] desc_out_offset,
    input  logic [NETSIZE-1:0] desc_net_offset,
    input  logic [NETSIZE-1:0] desc_net_stride,
    output logic               run_start,
    output logic [MEMSIZE-1:0] run_in_addr,
    output logic [MEMSIZE-1:0] run_out_addr,
    output logic [NETSIZE-1:0] run_net_addr,
    output logic               first_input,
    output logic               last_input,
    output logic [CORE-1:0]    core_mask,
    input  logic               run_done,
    output logic               layer_done,
    output logic               busy,
    output logic               ack
`ifdef RENKON_LAYER_PERF_EN
    ,
    output logic [31:0]        perf_cycles
`endif
);

    // Group stride is out_size*CORE; CORE is a power of two so this is a shift.
    localparam int CORE_SHIFT = $clog2(CORE);

    state_t             state;
    state_t             state_next;
    layer_desc_t        push_desc;
    layer_desc_t        head;
    logic               fifo_empty;
    logic               pop;
    logic [LWIDTH-1:0]  total_in;
    logic [LWIDTH-1:0]  idx;
    logic [LWIDTH-1:0]  remain;
    logic [MEMSIZE-1:0] in_offset;
    logic [MEMSIZE-1:0] in_size;
    logic [MEMSIZE-1:0] out_step;
    logic [NETSIZE-1:0] net_stride;
    logic               skip;
    logic               last_pass;

    function automatic logic [CORE-1:0] group_mask(input logic [LWIDTH-1:0] rem);
        logic [CORE-1:0] m;
        for (int k = 0; k < CORE; k++) begin
            m[k] = rem > LWIDTH'(k);
        end
        return m;
    endfunction

    assign push_desc = '{
        total_in:   desc_total_in,
        total_out:  desc_total_out,
        in_size:    desc_in_size,
        out_size:   desc_out_size,
        in_offset:  desc_in_offset,
        out_offset: desc_out_offset,
        net_offset: desc_net_offset,
        net_stride: desc_net_stride
    };

    renkon_desc_fifo #(
        .QDEPTH (QDEPTH),
        .desc_t (layer_desc_t)
    ) u_fifo (
        .clk       (clk),
        .xrst      (xrst),
        .clear     (clear),
        .push      (desc_valid),
        .push_desc (push_desc),
        .ready     (desc_ready),
        .pop       (pop),
        .pop_desc  (head),
        .empty     (fifo_empty)
    );

    assign last_pass  = (idx == total_in - LWIDTH'(1)) && (remain <= LWIDTH'(CORE));
    assign run_start  = (state == START) && !clear;
    assign busy       = (state != IDLE) || !fifo_empty;
    assign ack        = (state == IDLE) && fifo_empty;

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        layer_done = 1'b0;
        case (state)
            IDLE:  if (!fifo_empty) state_next = FETCH;
            FETCH: begin
                pop        = 1'b1;
                state_next = (head.total_in == '0 || head.total_out == '0) ? NEXT : START;
            end
            START: state_next = WAIT;
            WAIT:  if (run_done) state_next = NEXT;
            NEXT: begin
                if (skip || last_pass) begin
                    layer_done = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = START;
                end
            end
            default: state_next = IDLE;
        endcase
        if (clear) begin
            state_next = IDLE;
            layer_done = 1'b0;
        end
    end

    // Pass outputs only move in FETCH and NEXT, so they hold from START through WAIT.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            total_in     <= '0;
            in_offset    <= '0;
            in_size      <= '0;
            out_step     <= '0;
            net_stride   <= '0;
            idx          <= '0;
            remain       <= '0;
            skip         <= 1'b0;
            run_in_addr  <= '0;
            run_out_addr <= '0;
            run_net_addr <= '0;
            first_input  <= 1'b0;
            last_input   <= 1'b0;
            core_mask    <= '0;
        end else if (!clear) begin
            if (state == FETCH) begin
                total_in     <= head.total_in;
                in_offset    <= head.in_offset;
                in_size      <= head.in_size;
                out_step     <= head.out_size << CORE_SHIFT;
                net_stride   <= head.net_stride;
                idx          <= '0;
                remain       <= head.total_out;
                skip         <= (head.total_in == '0) || (head.total_out == '0);
                run_in_addr  <= head.in_offset;
                run_out_addr <= head.out_offset;
                run_net_addr <= head.net_offset;
                first_input  <= 1'b1;
                last_input   <= head.total_in == LWIDTH'(1);
                core_mask    <= group_mask(head.total_out);
            end else if (state == NEXT && !skip && !last_pass) begin
                run_net_addr <= run_net_addr + net_stride;
                if (idx == total_in - LWIDTH'(1)) begin
                    idx          <= '0;
                    remain       <= remain - LWIDTH'(CORE);
                    run_in_addr  <= in_offset;
                    run_out_addr <= run_out_addr + out_step;
                    core_mask    <= group_mask(remain - LWIDTH'(CORE));
                    first_input  <= 1'b1;
                    last_input   <= total_in == LWIDTH'(1);
                end else begin
                    idx          <= idx + LWIDTH'(1);
                    run_in_addr  <= run_in_addr + in_size;
                    first_input  <= 1'b0;
                    last_input   <= (idx + LWIDTH'(2)) == total_in;
                end
            end
        end
    end

`ifdef RENKON_LAYER_PERF_EN
    logic [31:0] perf_count;

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            perf_count  <= '0;
            perf_cycles <= '0;
        end else begin
            if (state == FETCH) begin
                perf_count <= 32'd1;
            end else if (state != IDLE && perf_count != '1) begin
                perf_count <= perf_count + 32'd1;
            end
            if (layer_done) begin
                perf_cycles <= (perf_count == '1) ? perf_count : perf_count + 32'd1;
            end
        end
    end
`endif

endmodule
